// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with registered byte/frame-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx #(
    parameter int BAUDRATE_DIVISOR = 100_000_000 / 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(BAUDRATE_DIVISOR);
    localparam int MID = BAUDRATE_DIVISOR / 2;
    localparam logic [CW-1:0] LAST = CW'(BAUDRATE_DIVISOR - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state, state_nx;
    logic sync1, rx_s, wrap, decide, bit_val, valid_nx, err_nx;
    logic [CW-1:0] baud_cnt, baud_cnt_nx;
    logic [3:0] bit_idx, bit_idx_nx;
    logic [7:0] shift_reg, shift_nx, data_nx;
    // Strobes are registered, so each decision is made one count early and lands in the cycle the counter reads MID.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] votes;
    assign decide = baud_cnt == CW'(MID);
    assign bit_val = (votes[1] & votes[0]) | (votes[1] & rx_s) | (votes[0] & rx_s);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) votes <= 2'b11;
        else if (baud_cnt == CW'(MID - 2) || baud_cnt == CW'(MID - 1)) votes <= {votes[0], rx_s};
`else
    assign decide = baud_cnt == CW'(MID - 1);
    assign bit_val = rx_s;
`endif
    assign wrap = baud_cnt == LAST;
    assign rx_busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_s, sync1} <= 2'b11;
        else {rx_s, sync1} <= {sync1, rx_bit};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            baud_cnt <= '0;
            bit_idx <= '0;
            shift_reg <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift_reg <= shift_nx;
            rx_data <= data_nx;
            rx_valid <= valid_nx;
            rx_frame_err <= err_nx;
        end
    end
    always_comb begin
        state_nx = state;
        baud_cnt_nx = wrap ? '0 : baud_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx = shift_reg;
        data_nx = rx_data;
        valid_nx = 1'b0;
        err_nx = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_nx = '0;
                bit_idx_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (decide && bit_val) begin
                    state_nx = IDLE;
                    baud_cnt_nx = '0;
                end else if (wrap) begin
                    state_nx = DATA;
                    bit_idx_nx = 4'd1;
                end
            end
            DATA: begin
                if (decide) shift_nx = {bit_val, shift_reg[7:1]};
                if (wrap) begin
                    bit_idx_nx = bit_idx + 4'd1;
                    if (bit_idx == 4'd8) state_nx = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    state_nx = bit_val ? IDLE : BREAK;
                    baud_cnt_nx = '0;
                    bit_idx_nx = '0;
                    valid_nx = bit_val;
                    err_nx = !bit_val;
                    data_nx = bit_val ? shift_reg : rx_data;
                end
            end
            default: begin
                baud_cnt_nx = '0;
                bit_idx_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frame vectors plus directed glitch, back-to-back and reset sequences.
module tb_uart_rx;
    localparam int D = 16;
    localparam int MID = D / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 3 + 9 * D + MID + 1;
    localparam int GLITCH_BUSY = 9;
    localparam logic [7:0] GL_DATA = 8'h00;
`else
    localparam int LAT = 3 + 9 * D + MID;
    localparam int GLITCH_BUSY = 8;
    localparam logic [7:0] GL_DATA = 8'h01;
`endif
    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         glitch;
        int         dvalid;
        int         derr;
        logic [7:0] exp_data;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, rx_bit = 1'b1;
    logic [7:0] rx_data;
    logic rx_valid, rx_frame_err, rx_busy;
    int checks = 0, failures = 0, cyc = 0;
    int nvalid = 0, nerr = 0, last_valid_cyc = -1, prev_valid_cyc = -1, last_err_cyc = -1;
    logic [7:0] data_at_valid = 8'h00;
    logic busy_at_valid = 1'b0, overlap = 1'b0, prev_pulse = 1'b0;
    vec_t vecs[5];

    uart_rx #(.BAUDRATE_DIVISOR(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_bit(rx_bit),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            data_at_valid = rx_data;
            busy_at_valid = rx_busy;
        end
        if (rx_frame_err) begin
            nerr++;
            last_err_cyc = cyc;
        end
        if ((rx_valid && rx_frame_err) || (prev_pulse && (rx_valid || rx_frame_err))) overlap = 1'b1;
        prev_pulse = rx_valid || rx_frame_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int glitch, input int len, output int c0);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        @(negedge clk);
        c0 = cyc;
        for (int j = 0; j < len; j++) begin
            if (j > 0) @(negedge clk);
            rx_bit = f[j / D] ^ (j == glitch);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0, c1, v0, e0, busy_sum;
        vecs[0] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5};
        vecs[1] = '{8'h55, 1'b0, -1, 0, 1, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, -1, 1, 0, 8'h3C};
        vecs[3] = '{8'h00, 1'b1, D + MID, 1, 0, GL_DATA};
        vecs[4] = '{8'h81, 1'b1, -1, 1, 0, 8'h81};
        repeat (3) @(negedge clk);
        #1;
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 0);
        chk("reset_err", rx_frame_err, 0);
        chk("reset_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v0 = nvalid;
            e0 = nerr;
            send(vecs[i].d, vecs[i].stop, vecs[i].glitch, 10 * D, c0);
            if (!vecs[i].stop) begin
                repeat (40) @(negedge clk);
                #1 chk("break_busy", rx_busy, 1);
                rx_bit = 1'b1;
                repeat (2) @(negedge clk);
                #1 chk("break_hold", rx_busy, 1);
                @(negedge clk);
                #1 chk("break_exit", rx_busy, 0);
                chk("err_latency", last_err_cyc - c0, LAT);
            end else begin
                repeat (2) @(negedge clk);
                #1;
                chk("valid_latency", last_valid_cyc - c0, LAT);
                chk("busy_at_valid", busy_at_valid, 0);
            end
            chk("valid_count", nvalid - v0, vecs[i].dvalid);
            chk("err_count", nerr - e0, vecs[i].derr);
            chk("rx_data", rx_data, vecs[i].exp_data);
        end

        v0 = nvalid;
        e0 = nerr;
        busy_sum = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            #1;
            busy_sum += int'(rx_busy);
            rx_bit = (i >= 4);
        end
        chk("glitch_busy_cycles", busy_sum, GLITCH_BUSY);
        chk("glitch_valid", nvalid - v0, 0);
        chk("glitch_err", nerr - e0, 0);
        chk("glitch_data", rx_data, 8'h81);

        v0 = nvalid;
        send(8'h00, 1'b1, -1, 10 * D, c0);
        chk("b2b_first_data", data_at_valid, 8'h00);
        send(8'hFF, 1'b1, -1, 10 * D, c1);
        repeat (2) @(negedge clk);
        #1;
        chk("b2b_count", nvalid - v0, 2);
        chk("b2b_gap", last_valid_cyc - prev_valid_cyc, 160);
        chk("b2b_second_data", rx_data, 8'hFF);

        send(8'h96, 1'b1, -1, 5 * D + 4, c0);
        #1 chk("midframe_busy", rx_busy, 1);
        rst_n = 1'b0;
        rx_bit = 1'b1;
        #1;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_busy", rx_busy, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err", rx_frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = nvalid;
        e0 = nerr;
        send(8'h3C, 1'b1, -1, 10 * D, c0);
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_count", nvalid - v0, 1);
        chk("post_rst_err", nerr - e0, 0);
        chk("post_rst_latency", last_valid_cyc - c0, LAT);
        chk("post_rst_data", rx_data, 8'h3C);
        chk("strobe_exclusive", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 RS-232 link: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. It sits directly downstream of the transmit line, on the opposite end from the transmitter. It recovers each byte from the asynchronous `rx_bit` input and presents it as a one-cycle strobe with its data. It uses the same clock and `BAUDRATE_DIVISOR` convention as the transmitter, so a loopback pair runs at the same rate.

## Interface
- `BAUDRATE_DIVISOR`, default `100_000_000/9600` (10416): clk cycles per bit period. Must be ≥ 8. `MID = BAUDRATE_DIVISOR/2` (integer divide).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_bit`  in  1  serial line, asynchronous, idles high.
- `rx_data`  out  8  last correctly framed byte; held until the next good byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `rx_busy`  out  1  high in every state except IDLE.

## Operation
- Input path: 2-flop synchronizer on `rx_bit`, both flops reset to 1. The FSM sees only the synchronized value `rx_s`.
- Counters:
  - `baud_cnt`, width `$clog2(BAUDRATE_DIVISOR)`, runs 0..DIVISOR-1 and wraps to 0.
  - `bit_idx` (4 bits) counts bit periods: 0 is start, 1–8 are data, 9 is stop.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `baud_cnt`=0, `bit_idx`=0. When `rx_s`=0, go to START.
  - START: at the sample point, if the bit is 0, keep counting. If the bit is 1 (glitch), go to IDLE with no outputs. When `baud_cnt`=DIVISOR-1, set `bit_idx` to 1 and go to DATA.
  - DATA: at the sample point, shift right into `shift_reg[7]`. On wrap, increment `bit_idx`. After `bit_idx` 8 wraps, go to STOP.
  - STOP: at the sample point:
    - bit = 1: load `rx_data` from `shift_reg`, pulse `rx_valid`, go to IDLE.
    - bit = 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE.
- Returning to IDLE at mid-stop lets a start edge that follows immediately be detected.
- `rx_valid` and `rx_frame_err` are never high in the same cycle, and never high two cycles in a row.
- Reset, including mid-frame: state IDLE, counters 0, `shift_reg`=0.
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
  - The synchronizer is set to 1.
  - Any partial byte is discarded.

## Timing
- Synchronizer latency is 2 cycles from the `rx_bit` pin to `rx_s`.
- Let edge k be the clk edge where IDLE sees `rx_s`=0; `baud_cnt`=0 in the following cycle.
- Sample point of bit period i is edge k + i·DIVISOR + MID, with a decision cycle offset of +1 when `UART_RX_MAJORITY_EN` is set.
- `rx_valid` / `rx_frame_err` are high for exactly the one cycle after edge k + 9·DIVISOR + MID (or +1 more with majority).
- `rx_busy` rises the cycle after edge k and falls in the same cycle `rx_valid` rises. After a framing error, `rx_busy` falls the cycle after BREAK sees `rx_s`=1.
- A line that is low in IDLE and still low after BREAK exits is treated as a new start edge.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit decision is a 2-of-3 majority of `rx_s` at `baud_cnt` = MID-1, MID and MID+1.
  - The decision is taken at MID+1.
  - This applies to the start-bit check, data bits and stop bit.
- Not defined: single sample of `rx_s` at `baud_cnt` = MID.

## Test plan
- DIVISOR=16, drive frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,1) → one `rx_valid` pulse at edge k+9·16+8 (+1 with macro), `rx_data`=0xA5, `rx_frame_err` never high.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the stop bit → two `rx_valid` pulses exactly 160 cycles apart, `rx_data` 0x00 then 0xFF.
- Low glitch of 4 cycles on an idle line → `rx_busy` high for ≈8 cycles then low; no `rx_valid` or `rx_frame_err` pulse; `rx_data` unchanged.
- Frame 0x55 with stop bit 0, line held low for 40 more cycles → one `rx_frame_err` pulse, `rx_data` keeps the previous 0xA5, `rx_busy` stays high until the line returns high.
- `rst_n` low for 3 cycles during data bit 4 → all outputs 0 immediately; the next full frame 0x3C is received correctly.
- Single-cycle high glitch at `baud_cnt`=MID of data bit 0 in 0x00 → with the macro, `rx_data`=0x00; without it, `rx_data`=0x01.
